// File: rtl/instruction_fetch_unit_pkg.sv
// Shared widths, jump-target field position and fetch FSM encoding for the fetch unit.
package instruction_fetch_unit_pkg;

  localparam int WORD_SIZE    = 16;
  localparam int TARGET_LOC_L = 11;
  localparam int TARGET_LOC_R = 0;

  typedef enum logic [1:0] {
    IF_IDLE  = 2'd0,
    IF_REQ   = 2'd1,
    IF_HOLD  = 2'd2,
    IF_RETRY = 2'd3
  } if_state_e;

  // J-format target: upper bits of pc+1 concatenated with the instruction's target field.
  function automatic logic [WORD_SIZE-1:0] jump_target(
    input logic [WORD_SIZE-1:0] pcp1,
    input logic [WORD_SIZE-1:0] instr
  );
    return {pcp1[WORD_SIZE-1:TARGET_LOC_L+1], instr[TARGET_LOC_L:TARGET_LOC_R]};
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_timer.sv
// Counts REQ cycles spent without a memory response; expire marks the last allowed cycle.
module fetch_timer #(
  parameter int TIMEOUT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) wait_cnt <= '0;
    else if (enable)    wait_cnt <= wait_cnt + 1'b1;
  end

  assign expire = (wait_cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/instruction_fetch_unit.sv
// Owns the PC, fetches one instruction per memory handshake and holds it until acknowledged.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [WORD_SIZE-1:0] RESET_PC = 16'h0000,
  parameter int                   TIMEOUT  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 readM,
  output logic [WORD_SIZE-1:0] address,
  input  logic [WORD_SIZE-1:0] data,
  input  logic                 inputReady,
  output logic [WORD_SIZE-1:0] instr,
  output logic                 instr_valid,
  input  logic                 instr_ack,
  input  logic                 Jump,
  output logic [WORD_SIZE-1:0] pc,
  output logic [WORD_SIZE-1:0] num_inst,
  output logic                 fetch_err
);

  if_state_e            state, state_nxt;
  logic                 expire;
  logic                 in_req, in_hold;
  logic                 got_rsp, retire;
  logic [WORD_SIZE-1:0] pcp1;

  assign in_req  = (state == IF_REQ);
  assign in_hold = (state == IF_HOLD);
  assign got_rsp = in_req & inputReady;
  assign retire  = in_hold & instr_ack;
  assign pcp1    = pc + 1'b1;

  // Timer only runs while a request is outstanding and unanswered.
  fetch_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (~in_req | inputReady | expire),
    .enable (in_req),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IF_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IF_IDLE:  state_nxt = IF_REQ;
      IF_REQ: begin
        if (inputReady)  state_nxt = IF_HOLD;
        else if (expire) state_nxt = IF_RETRY;
      end
      IF_HOLD:  if (instr_ack) state_nxt = IF_REQ;
      IF_RETRY: state_nxt = IF_REQ;
      default:  state_nxt = IF_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= RESET_PC;
      instr    <= '0;
      num_inst <= '0;
    end else begin
      if (got_rsp) instr <= data;
      if (retire) begin
        num_inst <= num_inst + 1'b1;
        pc       <= Jump ? jump_target(pcp1, instr) : pcp1;
      end
    end
  end

  assign readM       = in_req;
  assign instr_valid = in_hold;
  assign address     = pc;
  // Pulses on the last unanswered REQ cycle, the one that turns into RETRY.
  assign fetch_err   = in_req & ~inputReady & expire & ~reset;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: reference model, vector table, corner sequences, random run.
module tb_instruction_fetch_unit;

  localparam int TIMEOUT = 8;
  localparam logic [15:0] RST_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        reset, inputReady, instr_ack, Jump;
  logic [15:0] data;
  logic        readM, instr_valid, fetch_err;
  logic [15:0] address, instr, pc, num_inst;

  int checks = 0;
  int failures = 0;

  instruction_fetch_unit #(.RESET_PC(RST_PC), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .readM(readM), .address(address), .data(data),
    .inputReady(inputReady), .instr(instr), .instr_valid(instr_valid),
    .instr_ack(instr_ack), .Jump(Jump), .pc(pc), .num_inst(num_inst),
    .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  // Reference model: what the unit is doing expressed as plain flags.
  bit          m_idle, m_fetch, m_have, m_gap;
  int          m_wait;
  logic [15:0] m_pc, m_instr, m_cnt;

  task automatic chk1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [15:0] nxt;
    if (reset) begin
      m_idle = 1; m_fetch = 0; m_have = 0; m_gap = 0; m_wait = 0;
      m_pc = RST_PC; m_instr = '0; m_cnt = '0;
    end else if (m_idle) begin
      m_idle = 0; m_fetch = 1;
    end else if (m_fetch) begin
      if (inputReady) begin
        m_instr = data; m_fetch = 0; m_have = 1; m_wait = 0;
      end else if (m_wait == TIMEOUT - 1) begin
        m_fetch = 0; m_gap = 1; m_wait = 0;
      end else m_wait++;
    end else if (m_gap) begin
      m_gap = 0; m_fetch = 1;
    end else if (m_have && instr_ack) begin
      nxt = m_pc + 16'd1;
      m_pc = Jump ? {nxt[15:12], m_instr[11:0]} : nxt;
      m_cnt = m_cnt + 16'd1;
      m_have = 0; m_fetch = 1;
    end
  endtask

  // One clock: compare all outputs against the model mid-cycle, then advance.
  task automatic cyc();
    #4;
    chk1("readM", readM, m_fetch);
    chk1("instr_valid", instr_valid, m_have);
    chk1("fetch_err", fetch_err, m_fetch && !inputReady && (m_wait == TIMEOUT - 1) && !reset);
    chk16("address", address, m_pc);
    chk16("pc", pc, m_pc);
    chk16("instr", instr, m_instr);
    chk16("num_inst", num_inst, m_cnt);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic r, input logic ir, input logic [15:0] d,
                       input logic a, input logic j);
    reset = r; inputReady = ir; data = d; instr_ack = a; Jump = j;
  endtask

  // Expects to be entered in a fresh REQ; leaves in a fresh REQ.
  task automatic fetch_one(input logic [15:0] d, input logic j);
    drive(0, 1, d, 0, 0); cyc();
    drive(0, 0, 16'h0, 1, j); cyc();
    drive(0, 0, 16'h0, 0, 0);
  endtask

  task automatic goto_ffff();
    while (m_pc[15:12] != 4'hF) begin
      fetch_one(16'h0FFF, 1);
      fetch_one(16'h0000, 0);
    end
    fetch_one(16'h0FFF, 1);
  endtask

  typedef struct {
    logic rst, ir, ack, j;
    logic [15:0] d;
    logic e_rd, e_v;
    logic [15:0] e_pc, e_instr, e_num;
  } vec_t;

  vec_t tbl[4];
  logic [15:0] s_pc, s_instr, s_num;

  initial begin
    tbl[0] = '{rst:0, ir:0, ack:0, j:0, d:16'h0000, e_rd:0, e_v:0, e_pc:16'h0000, e_instr:16'h0000, e_num:16'd0};
    tbl[1] = '{rst:0, ir:1, ack:0, j:0, d:16'h6A05, e_rd:1, e_v:0, e_pc:16'h0000, e_instr:16'h0000, e_num:16'd0};
    tbl[2] = '{rst:0, ir:0, ack:1, j:0, d:16'h0000, e_rd:0, e_v:1, e_pc:16'h0000, e_instr:16'h6A05, e_num:16'd0};
    tbl[3] = '{rst:0, ir:0, ack:0, j:0, d:16'h0000, e_rd:1, e_v:0, e_pc:16'h0001, e_instr:16'h6A05, e_num:16'd1};

    drive(1, 0, 16'h0, 0, 0);
    @(posedge clk); model_edge(); #1;
    drive(1, 0, 16'h0, 0, 0); cyc();

    // Zero-wait fetch, ack in first HOLD cycle.
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].ir, tbl[i].d, tbl[i].ack, tbl[i].j);
      #2;
      chk1("t1_readM", readM, tbl[i].e_rd);
      chk1("t1_valid", instr_valid, tbl[i].e_v);
      chk16("t1_pc", pc, tbl[i].e_pc);
      chk16("t1_instr", instr, tbl[i].e_instr);
      chk16("t1_num", num_inst, tbl[i].e_num);
      cyc();
    end
    drive(0, 0, 16'h0, 0, 0);

    // Jump target keeps pc+1 upper nibble.
    fetch_one(16'h0FFF, 1);
    fetch_one(16'h0000, 0);
    fetch_one(16'h0233, 1);
    fetch_one(16'h0000, 0);
    #2 chk16("t2_pc_1234", pc, 16'h1234);
    fetch_one(16'h9ABC, 1);
    #2 chk16("t2_jump_addr", address, 16'h1ABC);
    fetch_one(16'h0233, 1);
    fetch_one(16'h0000, 0);
    fetch_one(16'h9ABC, 0);
    #2 chk16("t2_seq_addr", address, 16'h1235);

    // PC wrap at 16'hFFFF.
    goto_ffff();
    #2 chk16("t3_pc_ffff", pc, 16'hFFFF);
    fetch_one(16'h1111, 0);
    #2 chk16("t3_wrap_addr", address, 16'h0000);
    goto_ffff();
    fetch_one(16'h9123, 1);
    #2 chk16("t3_jump_wrap", address, 16'h0123);

    // Timeout, retry gap, then accept on third retried REQ cycle.
    s_pc = pc;
    for (int k = 1; k <= 8; k++) begin
      drive(0, 0, 16'h0, 0, 0);
      #2 chk1("t4_err", fetch_err, k == 8);
      cyc();
    end
    #2 chk1("t4_retry_readM", readM, 1'b0);
    chk1("t4_retry_err", fetch_err, 1'b0);
    drive(0, 1, 16'hDEAD, 0, 0); cyc();
    drive(0, 0, 16'h0, 0, 0); cyc();
    #2 chk16("t4_same_addr", address, s_pc);
    cyc();
    drive(0, 1, 16'h8FED, 0, 0); cyc();
    drive(0, 0, 16'h0, 0, 0);
    #2 chk1("t4_accept", instr_valid, 1'b1);
    chk16("t4_instr", instr, 16'h8FED);

    // Long HOLD with Jump but no ack, then one acked jump.
    s_pc = pc; s_instr = instr; s_num = num_inst;
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 16'h0, 0, 1);
      #2 chk16("t5_instr", instr, s_instr);
      chk16("t5_pc", pc, s_pc);
      chk16("t5_num", num_inst, s_num);
      chk1("t5_readM", readM, 1'b0);
      cyc();
    end
    drive(0, 0, 16'h0, 1, 1); cyc();
    drive(0, 0, 16'h0, 0, 1);
    s_pc = s_pc + 16'd1;
    #2 chk16("t5_jump", pc, {s_pc[15:12], 12'hFED});
    chk16("t5_num_inc", num_inst, s_num + 16'd1);
    cyc();
    #2 chk16("t5_jump_once", pc, {s_pc[15:12], 12'hFED});

    // Reset while in REQ, then while in HOLD.
    drive(1, 1, 16'h5555, 0, 0); cyc();
    drive(0, 0, 16'h0, 0, 0);
    #2 chk1("t6r_readM", readM, 1'b0);
    chk1("t6r_valid", instr_valid, 1'b0);
    chk16("t6r_pc", pc, RST_PC);
    chk16("t6r_num", num_inst, 16'd0);
    chk1("t6r_err", fetch_err, 1'b0);
    cyc();
    fetch_one(16'h0007, 0);
    drive(0, 1, 16'h4321, 0, 0); cyc();
    drive(1, 0, 16'h0, 1, 1); cyc();
    drive(0, 0, 16'h0, 0, 0);
    #2 chk1("t6h_valid", instr_valid, 1'b0);
    chk1("t6h_readM", readM, 1'b0);
    chk16("t6h_pc", pc, RST_PC);
    chk16("t6h_num", num_inst, 16'd0);
    chk16("t6h_instr", instr, 16'h0000);
    cyc();

    // Random traffic; memory responsiveness changes every 200 cycles.
    begin
      int thr;
      thr = 4;
      for (int n = 0; n < 3000; n++) begin
        if (n % 200 == 0) thr = $urandom_range(0, 8);
        drive(($urandom % 150) == 0, ($urandom % 8) < thr, 16'($urandom),
              $urandom % 2, $urandom % 2);
        cyc();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
